// File: rtl/lustre_step_ctrl.sv
// lustre_step_ctrl: instant sequencer for a compiled Lustre node.
// It accepts one input instant per valid/ready handshake and emits a
// one-cycle step strobe for that instant. It drives the shared fby init
// line, then holds the node outputs valid until the consumer takes them.
// Restart requests give the Lustre "reset ... every" behaviour.

module lustre_step_ctrl #(
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             restart,
  output logic             step,
  output logic             init,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] instant
);

  // Latency counter must hold the value LAT itself.
  localparam int LW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [LW-1:0]    LAT_L = LW'(LAT);
  localparam logic [LW-1:0]    ONE_L = LW'(1);
  localparam logic [CNT_W-1:0] SAT_L = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    HOLD = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             step_q, step_d;
  logic             init_q, init_d;
  logic [CNT_W-1:0] instant_q, instant_d;

  // State and datapath registers; reset aborts any instant in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= {LW{1'b0}};
      first_q   <= 1'b1;
      step_q    <= 1'b0;
      init_q    <= 1'b1;
      instant_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      step_q    <= step_d;
      init_q    <= init_d;
      instant_q <= instant_d;
    end
  end

  // Next-state logic: accept in IDLE, count latency in EVAL, handshake in HOLD.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    step_d    = 1'b0;
    init_d    = init_q;
    instant_d = instant_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          step_d  = 1'b1;
          init_d  = first_q | restart;
          cnt_d   = LAT_L;
          state_d = EVAL;
          if (restart) begin
            instant_d = {CNT_W{1'b0}};
          end else begin
            instant_d = instant_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EVAL: begin
        cnt_d = cnt_q - ONE_L;
        if (cnt_q == ONE_L) begin
          state_d = HOLD;
        end else begin
          state_d = EVAL;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          first_d = 1'b0;
          init_d  = 1'b0;
          if (instant_q == SAT_L) begin
            instant_d = instant_q;
          end else begin
            instant_d = instant_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode the state register directly, so they never overlap.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign step      = step_q;
  assign init      = init_q;
  assign instant   = instant_q;

endmodule
